// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port.
// LSU_READBACK_EN adds the VERIFY state used for post-store readback checking.
package lsu_pkg;

`ifdef LSU_READBACK_EN
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, VERIFY} lsu_state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} lsu_state_t;
`endif

   function automatic int len_sz(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   // Explicit compare so non-power-of-two depths wrap correctly.
   function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned m);
      return (addr == m - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/lsu_mem_port_addr_gen.sv
// Wrap-around address counter: loads a start address and word count, advances
// on enable until the final word, and flags when the current address is the last.
module lsu_addr_gen
   import lsu_pkg::*;
#(
   parameter int M      = 32,
   parameter int AddrSz = $clog2(M),
   parameter int LenSz  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              en_i,
   input  logic [AddrSz-1:0] addr_i,
   input  logic [LenSz-1:0]  cnt_i,
   output logic [AddrSz-1:0] addr_o,
   output logic              last_o
);

   logic [AddrSz-1:0] addr_q, addr_d;
   logic [LenSz-1:0]  rem_q, rem_d;

   assign last_o = (rem_q == LenSz'(1));
   assign addr_o = addr_q;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = addr_i;
         rem_d  = cnt_i;
      end else if (en_i && !last_o) begin
         addr_d = AddrSz'(wrap_inc(int'(addr_q), M));
         rem_d  = rem_q - LenSz'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store sequencer driving a synchronous RAM; streams load beats and store acks.
// Optional LSU_READBACK_EN: stores are re-read and compared before acking.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int N         = 8,
   parameter int M         = 32,
   parameter int AddrSz    = $clog2(M),
   parameter int MAX_BURST = 4,
   localparam int LenSz    = len_sz(MAX_BURST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AddrSz-1:0] req_addr,
   input  logic [N-1:0]      req_wdata,
   input  logic [LenSz-1:0]  req_len,
   output logic              resp_valid,
   output logic [N-1:0]      resp_data,
   output logic              resp_last,
   output logic              resp_err,
   output logic              busy,
   output logic [AddrSz-1:0] mem_addr,
   output logic [N-1:0]      mem_w_data,
   output logic              mem_w_en,
   input  logic [N-1:0]      mem_r_data
);

   lsu_state_t state_q, state_d;

   logic          wen_q, wen_d;
   logic [N-1:0]  wdata_q, wdata_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          rdat_vld_q, rdat_vld_d;
   logic          rlast_q, rlast_d;
   logic          rv_q, rv_d, rl_q, rl_d, re_q, re_d;
   logic [N-1:0]  rd_q, rd_d;
   logic          busy_q;
`ifdef LSU_READBACK_EN
   logic          vfy_wait_q, vfy_wait_d;
`endif

   logic              ag_load, ag_en, ag_last;
   logic [LenSz-1:0]  ag_cnt, len_eff;
   logic              oor;

   lsu_addr_gen #(.M(M), .AddrSz(AddrSz), .LenSz(LenSz)) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .load_i (ag_load),
      .en_i   (ag_en),
      .addr_i (req_addr),
      .cnt_i  (ag_cnt),
      .addr_o (mem_addr),
      .last_o (ag_last)
   );

   assign req_ready  = (state_q == IDLE);
   assign busy       = busy_q;
   assign mem_w_en   = wen_q;
   assign mem_w_data = wdata_q;
   assign resp_valid = rv_q;
   assign resp_last  = rl_q;
   assign resp_err   = re_q;
   assign resp_data  = rd_q;

   // Widened compare: only non-power-of-two depths can be out of range.
   assign oor = ({1'b0, req_addr} >= (AddrSz+1)'(M));

   always_comb begin
      len_eff = req_len;
      if (req_len == '0)
         len_eff = LenSz'(1);
      else if (req_len > LenSz'(MAX_BURST))
         len_eff = LenSz'(MAX_BURST);
   end

   always_comb begin
      state_d    = state_q;
      ag_load    = 1'b0;
      ag_en      = 1'b0;
      ag_cnt     = req_we ? LenSz'(1) : len_eff;
      wen_d      = 1'b0;
      wdata_d    = wdata_q;
      ack_d      = ack_q;
      err_d      = err_q;
      rdat_vld_d = (state_q == READ);
      rlast_d    = (state_q == READ) && ag_last;
      rv_d       = 1'b0;
      rl_d       = 1'b0;
      re_d       = 1'b0;
      rd_d       = '0;
`ifdef LSU_READBACK_EN
      vfy_wait_d = 1'b0;
`endif

      // RAM data returned for an address issued in READ becomes a beat here.
      if (rdat_vld_q) begin
         rv_d = 1'b1;
         rd_d = mem_r_data;
         rl_d = rlast_q;
      end

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            err_d = 1'b0;
            if (req_valid) begin
               if (oor) begin
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else if (req_we) begin
                  ag_load = 1'b1;
                  wen_d   = 1'b1;
                  wdata_d = req_wdata;
                  state_d = WRITE;
               end else begin
                  ag_load = 1'b1;
                  state_d = READ;
               end
            end
         end
         WRITE: begin
            ack_d = 1'b1;
`ifdef LSU_READBACK_EN
            state_d = VERIFY;
`else
            state_d = DRAIN;
`endif
         end
         READ: begin
            ag_en = 1'b1;
            if (ag_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (ack_q) begin
               rv_d = 1'b1;
               rl_d = 1'b1;
               re_d = err_q;
            end
            state_d = IDLE;
         end
`ifdef LSU_READBACK_EN
         // First cycle re-presents the address, second sees the RAM output.
         VERIFY: begin
            if (!vfy_wait_q) begin
               vfy_wait_d = 1'b1;
            end else begin
               err_d   = (mem_r_data != wdata_q);
               state_d = DRAIN;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdat_vld_q <= 1'b0;
         rlast_q    <= 1'b0;
         rv_q       <= 1'b0;
         rl_q       <= 1'b0;
         re_q       <= 1'b0;
         rd_q       <= '0;
         busy_q     <= 1'b0;
`ifdef LSU_READBACK_EN
         vfy_wait_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdat_vld_q <= rdat_vld_d;
         rlast_q    <= rlast_d;
         rv_q       <= rv_d;
         rl_q       <= rl_d;
         re_q       <= re_d;
         rd_q       <= rd_d;
         busy_q     <= (state_d != IDLE);
`ifdef LSU_READBACK_EN
         vfy_wait_q <= vfy_wait_d;
`endif
      end
   end

endmodule
